arm_multicycle_ctrl: RTL and testbench

- Multicycle control unit for the ARM-subset processor.
- Sits directly upstream of the register file. It drives the register file write enable (REGWRITE to WE3) and the register-address source selects (REGSRC), plus all datapath mux/enable signals.
- Holds the NZCV flags register, evaluates condition codes, and sequences each instruction through a Moore FSM.

---
 rtl/arm_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_arm_multicycle_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle control unit for the ARM-subset processor: Moore sequencer,
// NZCV flags register, condition evaluation and datapath control decode.
module arm_multicycle_ctrl #(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] COND,
    input  logic [1:0] OP,
    input  logic [5:0] FUNCT,
    input  logic [3:0] RD,
    input  logic [3:0] ALUFLAGS,
    output logic       PCWRITE,
    output logic       ADRSRC,
    output logic       MEMWRITE,
    output logic       IRWRITE,
    output logic       REGWRITE,
    output logic [1:0] RESULTSRC,
    output logic [1:0] ALUSRCA,
    output logic [1:0] ALUSRCB,
    output logic [1:0] ALUCONTROL,
    output logic [1:0] IMMSRC,
    output logic [1:0] REGSRC,
    output logic [3:0] FLAGS,
    output logic [3:0] STATE
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [3:0] out_state;
    logic [3:0] flags_q;
    logic       condex;
    logic       condq;
    logic [1:0] alu_dec;
    logic       cv_update;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       pcw_fetch;
    logic       pcw_branch;
    logic       irw_raw;
    logic       regw_raw;
    logic       memw_raw;
    logic       in_exec;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unused encodings fall back to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (OP)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = FUNCT[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = FUNCT[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = S_FETCH;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    always_comb begin
        condex = 1'b0;
        case (COND)
            4'b0000: condex = flag_z;
            4'b0001: condex = ~flag_z;
            4'b0010: condex = flag_c;
            4'b0011: condex = ~flag_c;
            4'b0100: condex = flag_n;
            4'b0101: condex = ~flag_n;
            4'b0110: condex = flag_v;
            4'b0111: condex = ~flag_v;
            4'b1000: condex = flag_c & ~flag_z;
            4'b1001: condex = ~flag_c | flag_z;
            4'b1010: condex = (flag_n == flag_v);
            4'b1011: condex = (flag_n != flag_v);
            4'b1100: condex = ~flag_z & (flag_n == flag_v);
            4'b1101: condex = flag_z | (flag_n != flag_v);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    always_comb begin
        alu_dec = ALU_ADD;
        case (FUNCT[4:1])
            4'b0100: alu_dec = ALU_ADD;
            4'b0010: alu_dec = ALU_SUB;
            4'b0000: alu_dec = ALU_AND;
            4'b1100: alu_dec = ALU_ORR;
            default: alu_dec = ALU_ADD;
        endcase
    end

    assign cv_update = (FUNCT[4:1] == 4'b0100) || (FUNCT[4:1] == 4'b0010);
    assign in_exec   = (state_q == S_EXECR) || (state_q == S_EXECI);

    // Condition is frozen at DECODE so the instruction's own flag write
    // cannot change its later gating.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            condq <= 1'b0;
        end else if (state_q == S_DECODE) begin
            condq <= condex;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            flags_q <= FLAGS_RST;
        end else if (in_exec && FUNCT[0] && condq) begin
            flags_q[3:2] <= ALUFLAGS[3:2];
            if (cv_update) begin
                flags_q[1:0] <= ALUFLAGS[1:0];
            end
        end
    end

    // While reset is held the muxes show FETCH values and enables are masked below
    assign out_state = RESET ? S_FETCH : state_q;

    always_comb begin
        pcw_fetch  = 1'b0;
        pcw_branch = 1'b0;
        irw_raw    = 1'b0;
        regw_raw   = 1'b0;
        memw_raw   = 1'b0;
        ADRSRC     = 1'b0;
        RESULTSRC  = 2'b00;
        ALUSRCA    = 2'b00;
        ALUSRCB    = 2'b00;
        ALUCONTROL = ALU_ADD;
        case (out_state)
            S_FETCH: begin
                irw_raw   = 1'b1;
                pcw_fetch = 1'b1;
                ALUSRCA   = 2'b01;
                ALUSRCB   = 2'b10;
                RESULTSRC = 2'b10;
            end
            S_DECODE: begin
                ALUSRCA   = 2'b01;
                ALUSRCB   = 2'b10;
                RESULTSRC = 2'b10;
            end
            S_MEMADR: ALUSRCB = 2'b01;
            S_MEMRD:  ADRSRC  = 1'b1;
            S_MEMWB: begin
                RESULTSRC = 2'b01;
                regw_raw  = 1'b1;
            end
            S_MEMWR: begin
                ADRSRC   = 1'b1;
                memw_raw = 1'b1;
            end
            S_EXECR: ALUCONTROL = alu_dec;
            S_EXECI: begin
                ALUSRCB    = 2'b01;
                ALUCONTROL = alu_dec;
            end
            S_ALUWB: regw_raw = 1'b1;
            S_BRANCH: begin
                ALUSRCB    = 2'b01;
                RESULTSRC  = 2'b10;
                pcw_branch = 1'b1;
            end
            default: begin
                pcw_fetch = 1'b0;
            end
        endcase
    end

    // R15 is not a writable register, so RD=1111 suppresses the write-back
    assign REGWRITE = ~RESET & regw_raw & condq & (RD != 4'b1111);
    assign MEMWRITE = ~RESET & memw_raw & condq;
    assign PCWRITE  = ~RESET & (pcw_fetch | (pcw_branch & condq));
    assign IRWRITE  = ~RESET & irw_raw;
    assign IMMSRC   = OP;
    assign REGSRC   = {OP == 2'b01, OP == 2'b10};
    assign FLAGS    = flags_q;
    assign STATE    = state_q;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Randomized bench for arm_multicycle_ctrl: an instruction-level model predicts
// the state walk, control outputs and NZCV flags for each instruction.
module tb_arm_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] COND;
  logic [1:0] OP;
  logic [5:0] FUNCT;
  logic [3:0] RD;
  logic [3:0] ALUFLAGS;
  logic       PCWRITE, ADRSRC, MEMWRITE, IRWRITE, REGWRITE;
  logic [1:0] RESULTSRC, ALUSRCA, ALUSRCB, ALUCONTROL, IMMSRC, REGSRC;
  logic [3:0] FLAGS, STATE;
  logic [16:0] outs_bus;

  int n_checks = 0;
  int n_pass = 0;
  logic [3:0] flags_m;
  logic [3:0] cmds [4] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};

  arm_multicycle_ctrl #(.FLAGS_RST(4'b0000)) dut (
    .CLK(CLK), .RESET(RESET), .COND(COND), .OP(OP), .FUNCT(FUNCT), .RD(RD),
    .ALUFLAGS(ALUFLAGS), .PCWRITE(PCWRITE), .ADRSRC(ADRSRC), .MEMWRITE(MEMWRITE),
    .IRWRITE(IRWRITE), .REGWRITE(REGWRITE), .RESULTSRC(RESULTSRC), .ALUSRCA(ALUSRCA),
    .ALUSRCB(ALUSRCB), .ALUCONTROL(ALUCONTROL), .IMMSRC(IMMSRC), .REGSRC(REGSRC),
    .FLAGS(FLAGS), .STATE(STATE)
  );

  // clock
  always #5 CLK = ~CLK;

  assign outs_bus = {PCWRITE, ADRSRC, MEMWRITE, IRWRITE, REGWRITE, RESULTSRC,
                     ALUSRCA, ALUSRCB, ALUCONTROL, IMMSRC, REGSRC};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    if (cmd == 4'b0010) return 2'b01;
    if (cmd == 4'b0000) return 2'b10;
    if (cmd == 4'b1100) return 2'b11;
    return 2'b00;
  endfunction

  // Expected control outputs for a given phase of the instruction
  function automatic logic [16:0] exp_outs(input int s, input bit rst, input bit pass,
                                           input logic [1:0] op, input logic [5:0] f,
                                           input logic [3:0] rd);
    logic pcw, adr, memw, irw, regw;
    logic [1:0] rs, sa, sb, ac, rsrc;
    bit wr_ok;
    pcw = 0; adr = 0; memw = 0; irw = 0; regw = 0;
    rs = 0; sa = 0; sb = 0; ac = 0;
    wr_ok = pass && (rd != 4'hF);
    case (s)
      0: begin irw = 1; pcw = 1; sa = 1; sb = 2; rs = 2; end
      1: begin sa = 1; sb = 2; rs = 2; end
      2: sb = 1;
      3: adr = 1;
      4: begin rs = 1; regw = wr_ok; end
      5: begin adr = 1; memw = pass; end
      6: ac = alu_of(f[4:1]);
      7: begin sb = 1; ac = alu_of(f[4:1]); end
      8: regw = wr_ok;
      9: begin sb = 1; rs = 2; pcw = pass; end
      default: ;
    endcase
    if (rst) begin pcw = 0; irw = 0; regw = 0; memw = 0; end
    rsrc = {op == 2'b01, op == 2'b10};
    return {pcw, adr, memw, irw, regw, rs, sa, sb, ac, op, rsrc};
  endfunction

  // Runs one instruction; abort_at >= 0 holds reset for two cycles at that phase
  task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input logic [3:0] af_exec, input int abort_at);
    int seq[$];
    bit pass, is_exec;
    pass = cond_ok(c, flags_m);
    case (op)
      2'b01:   seq = f[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
      2'b00:   seq = '{0, 1, (f[5] ? 7 : 6), 8};
      2'b10:   seq = '{0, 1, 9};
      default: seq = '{0, 1};
    endcase
    foreach (seq[i]) begin
      @(negedge CLK);
      COND = c; OP = op; FUNCT = f; RD = rd;
      is_exec = (seq[i] == 6) || (seq[i] == 7);
      ALUFLAGS = is_exec ? af_exec : 4'($urandom);
      if (i == abort_at) begin
        RESET = 1'b1;
        #1;
        check("rst_outs", outs_bus, exp_outs(0, 1, pass, op, f, rd));
        check("rst_memwrite", MEMWRITE, 0);
        @(negedge CLK);
        #1;
        flags_m = 4'b0000;
        check("rst_state", STATE, 0);
        check("rst_flags", FLAGS, flags_m);
        check("rst_outs2", outs_bus, exp_outs(0, 1, pass, op, f, rd));
        return;
      end
      RESET = 1'b0;
      #1;
      check("state", STATE, seq[i]);
      check("outs", outs_bus, exp_outs(seq[i], 0, pass, op, f, rd));
      check("flags", FLAGS, flags_m);
      if (is_exec && f[0] && pass) begin
        flags_m[3:2] = af_exec[3:2];
        if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010) flags_m[1:0] = af_exec[1:0];
      end
    end
  endtask

  initial begin
    logic [3:0] c, rd;
    logic [1:0] op;
    logic [5:0] f;
    RESET = 1'b1; COND = 4'hE; OP = 2'b00; FUNCT = 6'd0; RD = 4'd0; ALUFLAGS = 4'd0;
    flags_m = 4'b0000;
    @(negedge CLK); #1;
    check("init_outs", outs_bus, exp_outs(0, 1, 0, 2'b00, 6'd0, 4'd0));
    @(negedge CLK); #1;
    check("init_state", STATE, 0);
    check("init_flags", FLAGS, 0);

    // LDR, SUBS, ANDS
    run_instr(4'hE, 2'b01, 6'b011001, 4'd3, 4'h0, -1);
    run_instr(4'hE, 2'b00, 6'b000101, 4'd2, 4'b0110, -1);
    check("subs_flags", FLAGS, 4'b0110);
    run_instr(4'hE, 2'b00, 6'b000001, 4'd2, 4'b1001, -1);
    check("ands_flags", FLAGS, 4'b1010);
    // Z=1 then BNE / BEQ
    run_instr(4'hE, 2'b00, 6'b000101, 4'd1, 4'b0100, -1);
    run_instr(4'h1, 2'b10, 6'b000000, 4'd0, 4'h0, -1);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, -1);
    // ADD to R15, STR never, undefined
    run_instr(4'hE, 2'b00, 6'b001000, 4'hF, 4'h0, -1);
    run_instr(4'hF, 2'b01, 6'b011000, 4'd4, 4'h0, -1);
    run_instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'h0, -1);
    // Reset mid-MEMWR
    run_instr(4'hE, 2'b01, 6'b011000, 4'd4, 4'h0, 3);

    for (int k = 0; k < 200; k++) begin
      op = 2'($urandom_range(0, 3));
      c  = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      case (op)
        2'b00:   f = {1'($urandom), cmds[$urandom_range(0, 3)], 1'($urandom)};
        2'b01:   f = {2'b01, 3'($urandom), 1'($urandom)};
        default: f = 6'($urandom);
      endcase
      run_instr(c, op, f, rd, 4'($urandom), ($urandom_range(0, 19) == 0) ? 2 : -1);
    end
    run_instr(4'hE, 2'b10, 6'd0, 4'd0, 4'h0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
